// File: rtl/nasti_mc_pkg.sv
// Shared NASTI transaction types and protocol constants for the memory-controller
// front end and its core-side responder.
package nasti_mc_pkg;

  localparam int NASTI_ID_W   = 9;
  localparam int NASTI_ADDR_W = 32;
  localparam int NASTI_DATA_W = 64;
  localparam int NASTI_USER_W = 1;
  localparam int NASTI_STRB_W = NASTI_DATA_W / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [NASTI_ID_W-1:0]   id;
    logic [NASTI_ADDR_W-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [NASTI_USER_W-1:0] user;
  } aw_trans;

  typedef struct packed {
    logic [NASTI_ID_W-1:0]   id;
    logic [NASTI_ADDR_W-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic [NASTI_USER_W-1:0] user;
  } ar_trans;

  typedef struct packed {
    logic [NASTI_DATA_W-1:0] data;
    logic [NASTI_STRB_W-1:0] strb;
    logic                    last;
    logic [NASTI_USER_W-1:0] user;
  } w_trans;

  typedef struct packed {
    logic [NASTI_ID_W-1:0]   id;
    logic [1:0]              resp;
    logic [NASTI_USER_W-1:0] user;
  } b_trans;

  typedef struct packed {
    logic [NASTI_ID_W-1:0]   id;
    logic [NASTI_DATA_W-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    logic [NASTI_USER_W-1:0] user;
  } r_trans;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_DATA
  } resp_state_t;

  // Encodings rank DECERR > SLVERR > OKAY numerically; EXOKAY is never produced.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nasti_mem_array.sv
// Word array with per-byte write enables and a combinational read port;
// each byte lane is its own array so the tools can map lanes independently.
module nasti_mem_array #(
  parameter int WORDS  = 1024,
  parameter int DATA_W = 64,
  localparam int IDX_W  = $clog2(WORDS),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] rdata
);

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];

      always_ff @(posedge clk) begin
        if (we && wstrb[gi]) begin
          lane_mem[idx] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[idx];
    end
  endgenerate

endmodule

// File: rtl/nasti_mem_responder.sv
// Core-side NASTI responder: pops AW/W/AR from the clock-crossing FIFOs, services
// them against an on-chip array and pushes B/R responses back.
module nasti_mem_responder
  import nasti_mc_pkg::*;
#(
  parameter int C_NASTI_ID_WIDTH   = NASTI_ID_W,
  parameter int C_NASTI_ADDR_WIDTH = NASTI_ADDR_W,
  parameter int C_NASTI_DATA_WIDTH = NASTI_DATA_W,
  parameter int C_NASTI_USER_WIDTH = NASTI_USER_W,
  parameter int C_MEM_WORDS        = 1024
) (
  input  logic    core_clk,
  input  logic    core_arstn,
  input  aw_trans rdata_aw,
  input  logic    rempty_aw,
  output logic    rinc_aw,
  input  w_trans  rdata_w,
  input  logic    rempty_w,
  output logic    rinc_w,
  input  ar_trans rdata_ar,
  input  logic    rempty_ar,
  output logic    rinc_ar,
  output b_trans  wdata_b,
  input  logic    wfull_b,
  output logic    winc_b,
  output r_trans  wdata_r,
  input  logic    wfull_r,
  output logic    winc_r
);

  localparam int BYTES = C_NASTI_DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(BYTES);
  localparam int IDX_W = $clog2(C_MEM_WORDS);
  localparam logic [C_NASTI_ADDR_WIDTH:0]   MEM_BYTES   = (C_NASTI_ADDR_WIDTH+1)'(C_MEM_WORDS * BYTES);
  localparam logic [C_NASTI_ADDR_WIDTH-1:0] ADDR_STEP   = C_NASTI_ADDR_WIDTH'(BYTES);
  localparam logic [2:0]                    SIZE_NATIVE = 3'(OFFS);

  resp_state_t                   state_reg, state_next;
  logic [C_NASTI_ID_WIDTH-1:0]   id_reg;
  logic [C_NASTI_ADDR_WIDTH-1:0] addr_reg;
  logic [7:0]                    len_reg;
  logic [2:0]                    size_reg;
  logic [1:0]                    burst_reg;
  logic [C_NASTI_USER_WIDTH-1:0] user_reg;
  logic [7:0]                    beat_reg;
  logic [1:0]                    resp_reg;
  logic                          prefer_wr_reg;
  logic                          wlast_err_reg;

  logic                          cfg_err, range_err, last_beat, grant_wr, grant_rd;
  logic [1:0]                    beat_resp;
  logic [C_NASTI_ADDR_WIDTH-1:0] addr_adv;
  logic                          mem_we;
  logic [C_NASTI_DATA_WIDTH-1:0] mem_rdata;
  logic                          unused_ok;

  assign cfg_err   = (burst_reg == BURST_WRAP) || (burst_reg == 2'b11) || (size_reg != SIZE_NATIVE);
  assign range_err = {1'b0, addr_reg} >= MEM_BYTES;
  assign beat_resp = range_err ? RESP_DECERR : (cfg_err ? RESP_SLVERR : RESP_OKAY);
  assign last_beat = (beat_reg == len_reg);
  assign addr_adv  = (burst_reg == BURST_FIXED) ? addr_reg : addr_reg + ADDR_STEP;
  assign grant_wr  = !rempty_aw && (rempty_ar || prefer_wr_reg);
  assign grant_rd  = !rempty_ar && (rempty_aw || !prefer_wr_reg);
  assign unused_ok = ^{rdata_w.user, wlast_err_reg};

  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (grant_wr)      state_next = ST_WR_DATA;
        else if (grant_rd) state_next = ST_RD_DATA;
      end
      ST_WR_DATA: if (!rempty_w && last_beat) state_next = ST_WR_RESP;
      ST_WR_RESP: if (!wfull_b)               state_next = ST_IDLE;
      ST_RD_DATA: if (!wfull_r && last_beat)  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Handshakes are gated by reset so nothing is popped or pushed while held in reset.
  always_comb begin
    rinc_aw = 1'b0;
    rinc_ar = 1'b0;
    rinc_w  = 1'b0;
    winc_b  = 1'b0;
    winc_r  = 1'b0;
    mem_we  = 1'b0;
    wdata_b = '0;
    wdata_r = '0;
    if (core_arstn) begin
      case (state_reg)
        ST_IDLE: begin
          rinc_aw = grant_wr;
          rinc_ar = grant_rd;
        end
        ST_WR_DATA: begin
          rinc_w = !rempty_w;
          mem_we = !rempty_w && (beat_resp == RESP_OKAY);
        end
        ST_WR_RESP: begin
          winc_b       = !wfull_b;
          wdata_b.id   = id_reg;
          wdata_b.resp = resp_reg;
          wdata_b.user = user_reg;
        end
        ST_RD_DATA: begin
          winc_r       = !wfull_r;
          wdata_r.id   = id_reg;
          wdata_r.data = (beat_resp == RESP_OKAY) ? mem_rdata : '0;
          wdata_r.resp = beat_resp;
          wdata_r.last = last_beat;
          wdata_r.user = user_reg;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (!core_arstn) begin
      prefer_wr_reg <= 1'b1;
      wlast_err_reg <= 1'b0;
      beat_reg      <= '0;
      resp_reg      <= RESP_OKAY;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          beat_reg <= '0;
          resp_reg <= RESP_OKAY;
          if (grant_wr) begin
            id_reg        <= rdata_aw.id;
            addr_reg      <= rdata_aw.addr;
            len_reg       <= rdata_aw.len;
            size_reg      <= rdata_aw.size;
            burst_reg     <= rdata_aw.burst;
            user_reg      <= rdata_aw.user;
            prefer_wr_reg <= 1'b0;
            wlast_err_reg <= 1'b0;
          end else if (grant_rd) begin
            id_reg        <= rdata_ar.id;
            addr_reg      <= rdata_ar.addr;
            len_reg       <= rdata_ar.len;
            size_reg      <= rdata_ar.size;
            burst_reg     <= rdata_ar.burst;
            user_reg      <= rdata_ar.user;
            prefer_wr_reg <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (!rempty_w) begin
            beat_reg <= beat_reg + 8'd1;
            addr_reg <= addr_adv;
            resp_reg <= resp_worst(resp_reg, beat_resp);
            // Misplaced last is flagged only; beats are still counted against len.
            if (rdata_w.last != last_beat) wlast_err_reg <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (!wfull_r) begin
            beat_reg <= beat_reg + 8'd1;
            addr_reg <= addr_adv;
          end
        end
        default: ;
      endcase
    end
  end

  nasti_mem_array #(
    .WORDS  (C_MEM_WORDS),
    .DATA_W (C_NASTI_DATA_WIDTH)
  ) u_array (
    .clk   (core_clk),
    .we    (mem_we),
    .idx   (addr_reg[OFFS +: IDX_W]),
    .wdata (rdata_w.data),
    .wstrb (rdata_w.strb),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/nasti_mem_responder.md
# nasti_mem_responder

Core-clock transaction responder sitting on the far side of the `nasti_frontend` clock-crossing FIFOs. It pops AW/W/AR transactions, services them against an on-chip word array, and pushes B/R responses back. It is the consumer for the frontend's request FIFOs and the producer for its response FIFOs. It serves as the controller backend for bring-up and simulation before the DFI scheduler exists.

## Interface
- C_NASTI_ID_WIDTH, 9, transaction ID width
- C_NASTI_ADDR_WIDTH, 32, byte address width
- C_NASTI_DATA_WIDTH, 64, data bus width (bytes = DATA/8, power of two)
- C_NASTI_USER_WIDTH, 1, user field width
- C_MEM_WORDS, 1024, array depth in data-width words (power of two)
- core_clk  in  1  sole clock
- core_arstn  in  1  synchronous, active-low reset, sampled on core_clk
- rdata_aw / rempty_aw / rinc_aw  in/in/out  aw_trans/1/1  write-address FIFO read port
- rdata_w / rempty_w / rinc_w  in/in/out  w_trans/1/1  write-data FIFO read port
- rdata_ar / rempty_ar / rinc_ar  in/in/out  ar_trans/1/1  read-address FIFO read port
- wdata_b / wfull_b / winc_b  out/in/out  b_trans/1/1  write-response FIFO write port
- wdata_r / wfull_r / winc_r  out/in/out  r_trans/1/1  read-data FIFO write port

## Operation
- FIFO semantics: read ports are show-ahead. `rdata_*` is valid whenever `rempty_*`=0, and `rinc_*`=1 pops it at the clock edge. Write ports accept `wdata_*` at the edge when `winc_*`=1, which is only asserted while `wfull_*`=0.
- Word index = addr[log2(DATA/8) +: log2(C_MEM_WORDS)]. Address ≥ C_MEM_WORDS·DATA/8 is out of range.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE, only AW non-empty:
  - assert rinc_aw;
  - latch id, addr, len, burst, size, user;
  - beat counter = 0, go to WR_DATA.
- IDLE, only AR non-empty: assert rinc_ar, latch the same fields, go to RD_DATA.
- IDLE, both non-empty: grant the class not granted last. After reset, writes are favoured.
- WR_DATA:
  - each cycle rempty_w=0: assert rinc_w and write bytes where strb=1;
  - counter++, address += DATA/8 unless burst=FIXED.
  - After beat len (len+1 beats) go to WR_RESP.
  - w.last must be 1 on exactly beat len, else error flag set. Beats are still consumed by count.
- WR_RESP: when wfull_b=0, assert winc_b with {id, resp, user}, then go to IDLE.
- RD_DATA:
  - each cycle wfull_r=0: assert winc_r with {id, data, resp, last=(counter==len), user};
  - counter++, address update as for writes.
  - After beat len, go to IDLE.
- Error rules, recorded per beat:
  - burst=WRAP or reserved, or size≠log2(DATA/8): SLVERR (2'b10) on all beats.
  - Out-of-range beat: DECERR (2'b11).
  - B resp = worst seen: DECERR > SLVERR > OKAY.
  - Erroring write beats do not modify the array. Erroring read beats return data 0.
- Counter is 8 bits; len is 0–255.
- Address arithmetic wraps modulo 2^C_NASTI_ADDR_WIDTH.

## Timing
- While core_arstn=0:
  - all rinc_*/winc_* forced 0;
  - wdata_b/wdata_r = 0;
  - FSM→IDLE, arbitration flag→write;
  - array contents not reset.
- Reset mid-burst abandons the transaction. No B or R is produced for it, and remaining W beats stay in the FIFO.
- Array read is combinational (distributed), so R data reflects the current address in the same cycle.
- Read latency: AR popped at edge N; first winc_r possible in cycle N+1. Back-to-back beats one per cycle when not full.
- Write latency: AW popped at edge N; first W beat at N+1. B push in the cycle after the last W beat, if not full.
- IDLE spends one cycle per grant. Minimum gap between transactions is one cycle.
- rinc_* and winc_* are combinational from registered state and the current empty/full flags. They are never asserted against empty/full.

## Structure
- Shared package `nasti_mc_pkg`:
  - aw_trans / ar_trans {id, addr, len[7:0], size[2:0], burst[1:0], user}
  - w_trans {data, strb, last, user}
  - b_trans {id, resp[1:0], user}
  - r_trans {id, data, resp, last, user}
  - constants BURST_FIXED/INCR/WRAP and RESP_OKAY/EXOKAY/SLVERR/DECERR
- Sub-module `nasti_mem_array`: C_MEM_WORDS×DATA array, synchronous byte-strobed write, combinational read.

## Test plan
- AW {id=5, addr=0x40, len=3, INCR} plus 4 W beats 0x11..0x44 with strb=0xFF and last on beat 3 → B {id=5, OKAY}. Follow-up AR of the same burst → 4 R beats 0x11..0x44, last only on beat 3.
- Write with strb=0x0F on word holding 0xFFFF_FFFF_FFFF_FFFF, data 0 → read back 0xFFFF_FFFF_0000_0000.
- AW and AR both waiting at reset exit → write granted first, then read. The next simultaneous pair alternates.
- Hold wfull_r=1 for 5 cycles mid-burst → winc_r stays 0, no beat lost or duplicated, same counter resumes.
- AR addr just below the top word, len=1 → beat 0 OKAY with data; beat 1 DECERR, data 0, last=1. WRAP AW → B SLVERR, array unchanged.
- Assert core_arstn=0 during WR_DATA beat 2 → next cycle all rinc/winc=0 and state IDLE. No B is emitted.
